// File: rtl/sram_1w1r_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sram_1w1r_fifo_ctrl
//
// Streaming FIFO controller for an external 1-write/1-read OpenRAM macro.
// The macro registers its inputs at posedge and presents read data one cycle
// later. That latency is hidden behind valid/ready handshakes on both sides
// by a 2-entry registered output buffer.
//
// Ports:
//   clk, rstb                     single clock, async active-low reset
//   in_valid/in_ready/in_data     producer handshake
//   out_valid/out_ready/out_data  consumer handshake (out_data registered)
//   level                         words held (SRAM + in-flight read + buffer)
//   sram_csb0/addr0/din0          macro write port (csb active low)
//   sram_csb1/addr1, sram_dout1   macro read port
//   hwm_clr, hwm                  high-water mark of level (only when
//                                 SRAM_FIFO_CTRL_HWM_EN is defined)
// ---------------------------------------------------------------------------
module sram_1w1r_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 120,
    parameter int unsigned ADDR_WIDTH = 5,
    localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstb,
`ifdef SRAM_FIFO_CTRL_HWM_EN
    input  logic                  hwm_clr,
    output logic [ADDR_WIDTH+1:0] hwm,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam int unsigned PtrW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] FullOcc = PtrW'(RAM_DEPTH);

    // Pointers carry a wrap bit so full (occ == RAM_DEPTH) and empty differ.
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   occ;
    logic                  rd_pend_q, rd_pend_d;

    // Output buffer: ob0 is the head, ob1 the second entry.
    logic [DATA_WIDTH-1:0] ob0_q, ob0_d;
    logic [DATA_WIDTH-1:0] ob1_q, ob1_d;
    logic [1:0]            ob_cnt_q, ob_cnt_d;
    logic [1:0]            fill_slot;

    logic                  push;
    logic                  pop;
    logic                  issue;

    assign occ       = wptr_q - rptr_q;
    assign in_ready  = rstb && (occ != FullOcc);
    assign push      = in_valid && in_ready;
    assign out_valid = (ob_cnt_q != 2'd0);
    assign pop       = out_valid && out_ready;

    // Slot the returning read lands in, after any pop has shifted the buffer.
    assign fill_slot = ob_cnt_q - {1'b0, pop};
    assign ob_cnt_d  = fill_slot + {1'b0, rd_pend_q};

    // ob_cnt_d already counts the read in flight, so a new read is only
    // issued when its data is guaranteed a free slot on return.
    assign issue = (occ != '0) && (ob_cnt_d < 2'd2);

    // Reads only cover addresses below the registered wptr, so addr1 never
    // equals addr0 while both ports are enabled.
    assign sram_csb0  = !push;
    assign sram_addr0 = wptr_q[ADDR_WIDTH-1:0];
    assign sram_din0  = in_data;
    assign sram_csb1  = !issue;
    assign sram_addr1 = rptr_q[ADDR_WIDTH-1:0];

    assign out_data = ob0_q;
    assign level    = {1'b0, occ}
                    + {{(ADDR_WIDTH + 1){1'b0}}, rd_pend_q}
                    + {{ADDR_WIDTH{1'b0}}, ob_cnt_q};

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        rd_pend_d = issue;
        ob0_d     = ob0_q;
        ob1_d     = ob1_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (issue) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (pop) begin
            ob0_d = ob1_q;
        end
        // dout1 is only valid at this edge; capture it into the tail.
        if (rd_pend_q) begin
            if (fill_slot == 2'd0) begin
                ob0_d = sram_dout1;
            end else begin
                ob1_d = sram_dout1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_pend_q <= 1'b0;
            ob_cnt_q  <= 2'd0;
            ob0_q     <= '0;
            ob1_q     <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rd_pend_q <= rd_pend_d;
            ob_cnt_q  <= ob_cnt_d;
            ob0_q     <= ob0_d;
            ob1_q     <= ob1_d;
        end
    end

`ifdef SRAM_FIFO_CTRL_HWM_EN
    logic [ADDR_WIDTH+1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (hwm_clr || (level > hwm_q)) begin
            hwm_d = level;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_sram_1w1r_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_1w1r_fifo_ctrl
//
// Self-checking bench: behavioural 1W1R SRAM (registered inputs, access at
// negedge, dout valid for one posedge then garbage) plus a queue-based
// reference FIFO. Every handshake observed at the negedge updates the queue.
// Every pop is compared against the queue head.
// ---------------------------------------------------------------------------
module tb_sram_1w1r_fifo_ctrl;

    localparam int DW    = 120;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rstb;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW+1:0] level;
    logic          sram_csb0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic          sram_csb1;
    logic [AW-1:0] sram_addr1;
    logic [DW-1:0] sram_dout1;
`ifdef SRAM_FIFO_CTRL_HWM_EN
    logic          hwm_clr;
    logic [AW+1:0] hwm;
`endif

    sram_1w1r_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
`ifdef SRAM_FIFO_CTRL_HWM_EN
        .hwm_clr    (hwm_clr),
        .hwm        (hwm),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .sram_csb0  (sram_csb0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rnd_word();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // ---------------- behavioural SRAM macro ----------------
    logic [DW-1:0] mem [DEPTH];
    logic          csb0_r, csb1_r;
    logic [AW-1:0] a0_r, a1_r;
    logic [DW-1:0] d0_r;
    logic          collide = 1'b0;

    // Macro inputs are stable from the negedge up to the next posedge, so the
    // values latched at a negedge are the ones the macro registers at the
    // following posedge; the access itself happens at the negedge after that.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = rnd_word();
        csb0_r     = 1'b1;
        csb1_r     = 1'b1;
        a0_r       = '0;
        a1_r       = '0;
        d0_r       = '0;
        sram_dout1 = rnd_word();
        forever begin
            @(negedge clk);
            if (!csb0_r && !csb1_r && (a0_r == a1_r)) collide = 1'b1;
            if (!csb1_r) sram_dout1 = mem[a1_r];
            if (!csb0_r) mem[a0_r] = d0_r;
            csb0_r = sram_csb0;
            a0_r   = sram_addr0;
            d0_r   = sram_din0;
            csb1_r = sram_csb1;
            a1_r   = sram_addr1;
            @(posedge clk);
            #1 sram_dout1 = rnd_word();
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] q[$];
    int            n_push = 0;
    int            n_pop  = 0;
    logic          last_ov, last_ir, last_csb0, last_push, last_pop;
    logic [AW+1:0] last_level;

    // One clock cycle: sample at the negedge, update the model with the
    // handshakes that complete at the next posedge, return at posedge + 1.
    task automatic step();
        logic [DW-1:0] exp;
        @(negedge clk);
        last_ov    = out_valid;
        last_ir    = in_ready;
        last_csb0  = sram_csb0;
        last_level = level;
        last_push  = in_valid && in_ready;
        last_pop   = out_valid && out_ready;
        chk("level", 128'(level), 128'(q.size()));
        if (q.size() < DEPTH) chk("in_ready_room", 128'(in_ready), 128'(1));
        if (q.size() >= DEPTH + 2) chk("in_ready_full", 128'(in_ready), 128'(0));
        chk("csb0_vs_push", 128'(sram_csb0), 128'(!last_push));
        if (last_push) chk("din0", 128'(sram_din0), 128'(in_data));
        if (q.size() == 0) begin
            chk("out_valid_empty", 128'(out_valid), 128'(0));
            chk("csb1_empty", 128'(sram_csb1), 128'(1));
        end
        if (last_pop && q.size() > 0) begin
            exp = q.pop_front();
            chk("out_data", 128'(out_data), 128'(exp));
            n_pop++;
        end
        if (last_push) begin
            q.push_back(in_data);
            n_push++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_out_data"}, 128'(out_data), 128'(0));
        chk({tag, "_level"}, 128'(level), 128'(0));
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(0));
        chk({tag, "_csb0"}, 128'(sram_csb0), 128'(1));
        chk({tag, "_csb1"}, 128'(sram_csb1), 128'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base_push;
        int base_pop;

        rstb      = 1'b0;
        in_valid  = 1'b1;
        in_data   = rnd_word();
        out_ready = 1'b0;
`ifdef SRAM_FIFO_CTRL_HWM_EN
        hwm_clr   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rstb     = 1'b1;
        in_valid = 1'b0;

        // Single push: out_valid two cycles after the accepting edge.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = DW'(1);
        step();
        chk("lat_accept", 128'(last_push), 128'(1));
        in_valid = 1'b0;
        step();
        chk("lat_cyc_n", 128'(last_ov), 128'(0));
        step();
        chk("lat_cyc_n1", 128'(last_ov), 128'(0));
        step();
        chk("lat_cyc_n2", 128'(last_ov), 128'(1));
        chk("lat_pop", 128'(last_pop), 128'(1));
        step();
        chk("lat_level_after", 128'(last_level), 128'(0));

        // Fill: 34 back-to-back pushes, then held off.
        out_ready = 1'b0;
        cyc = 0;
        for (int v = 0; v < DEPTH + 2; v++) begin
            in_valid = 1'b1;
            in_data  = DW'(v);
            do begin
                step();
                cyc++;
            end while (!last_push && cyc < 200);
        end
        chk("fill_cycles", 128'(cyc), 128'(DEPTH + 2));
        in_data = DW'(999);
        repeat (4) begin
            step();
            chk("full_in_ready", 128'(last_ir), 128'(0));
            chk("full_csb0", 128'(last_csb0), 128'(1));
            chk("full_level", 128'(last_level), 128'(DEPTH + 2));
        end

        // Drain: 34 pops with no bubbles, values 0..33 via the model.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 2) begin
            step();
            chk("drain_nobubble", 128'(last_pop), 128'(1));
        end
        step();
        chk("drain_empty", 128'(last_level), 128'(0));

        // Random streaming: 200 words, random valid/ready.
        base_push = n_push;
        base_pop  = n_pop;
        cyc       = 0;
        while ((n_pop - base_pop) < 200 && cyc < 4000) begin
            in_valid  = ((n_push - base_push) < 200) && ($urandom_range(3) != 0);
            in_data   = rnd_word();
            out_ready = $urandom_range(1) != 0;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk("rand_pushed", 128'(n_push - base_push), 128'(200));
        chk("rand_popped", 128'(n_pop - base_pop), 128'(200));
        chk("sram_collision", 128'(collide), 128'(0));

        // Reset mid-stream with a read in flight and the buffer occupied.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (3) begin
            in_data = rnd_word();
            step();
        end
        chk("pre_reset_level", 128'(level), 128'(3));
        #2;
        rstb = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        q.delete();
        @(posedge clk);
        #1;
        chk_reset_outputs("midreset_hold");
        rstb      = 1'b1;
        in_valid  = 1'b1;
        in_data   = DW'(120'hABC);
        out_ready = 1'b1;
        step();
        chk("post_reset_accept", 128'(last_push), 128'(1));
        in_valid = 1'b0;
        base_pop = n_pop;
        cyc      = 0;
        while (n_pop == base_pop && cyc < 10) begin
            step();
            cyc++;
        end
        chk("post_reset_pop", 128'(n_pop - base_pop), 128'(1));

`ifdef SRAM_FIFO_CTRL_HWM_EN
        // High-water mark: 10 words in, all out, then clear.
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (10) begin
            in_data = rnd_word();
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc       = 0;
        while (q.size() != 0 && cyc < 50) begin
            step();
            cyc++;
        end
        step();
        step();
        chk("hwm_peak", 128'(hwm), 128'(10));
        hwm_clr = 1'b1;
        step();
        hwm_clr = 1'b0;
        chk("hwm_cleared", 128'(hwm), 128'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
